// File: rtl/stim_stream_player_if.sv
// Record stream carried from stim_stream_player to its sink.
interface stim_stream_player_if #(
  parameter int DATA_W = 16
);
  logic              out_valid;
  logic              out_st;
  logic              out_end;
  logic [DATA_W-1:0] out_data;
  logic              out_rdy;

  modport master (output out_valid, output out_st, output out_end, output out_data, input out_rdy);
  modport slave  (input out_valid, input out_st, input out_end, input out_data, output out_rdy);
endinterface

// File: rtl/stim_stream_player.sv
// Replays a preloaded window of {st,end,dv,data} records onto a stream with loop count,
// gap records, optional backpressure and frame-aligned stop.
module stim_stream_player #(
  parameter int DATA_W  = 16,
  parameter int AW      = 12,
  parameter bit USE_RDY = 1'b1
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  input  logic                wr_en,
  input  logic [AW-1:0]       wr_addr,
  input  logic [DATA_W+2:0]   wr_data,
  input  logic                start,
  input  logic                stop,
  input  logic [AW-1:0]       base_addr,
  input  logic [AW-1:0]       end_addr,
  input  logic [15:0]         loop_cnt,
  stim_stream_player_if.master strm,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [15:0]         passes
);
  localparam int RW = DATA_W + 3;

  typedef enum logic [1:0] {IDLE = 2'd0, PRIME = 2'd1, PLAY = 2'd2, DRAIN = 2'd3} state_t;

  // Gap records (dv=0) are presented as all-zero regardless of their st/end/data bits.
  function automatic logic [RW-1:0] mask_gap(input logic [RW-1:0] rec);
    if (rec[DATA_W]) mask_gap = rec;
    else             mask_gap = {RW{1'b0}};
  endfunction

  logic [RW-1:0]     mem_r [0:(1<<AW)-1];
  state_t            state_r;
  logic [AW-1:0]     addr_r, base_r, end_r;
  logic [15:0]       loop_r, passes_r;
  logic              open_r, stop_pend_r, busy_r, done_r, err_r;
  logic              valid_r, st_r, rec_end_r;
  logic [DATA_W-1:0] data_r;

  logic              adv_s, last_s, loop_done_s, open_nx_s, stop_now_s;
  logic [AW-1:0]     next_addr_s, rd_addr_s;
  logic [15:0]       passes_nx_s;
  logic [RW-1:0]     rd_rec_s;

  // Advance, wrap, pass and stop decisions for the record currently on the outputs.
  always_comb begin
    adv_s  = !valid_r || !USE_RDY || strm.out_rdy;
    last_s = (addr_r == end_r);
    if (last_s) next_addr_s = base_r;
    else        next_addr_s = addr_r + AW'(1'b1);
    passes_nx_s = passes_r + 16'd1;
    loop_done_s = last_s && (loop_r != 16'd0) && (passes_nx_s == loop_r);
    if (valid_r) open_nx_s = !rec_end_r;
    else         open_nx_s = open_r;
    stop_now_s = (stop_pend_r || stop) && !open_nx_s;
    if (state_r == PRIME) rd_addr_s = addr_r;
    else                  rd_addr_s = next_addr_s;
  end

  assign rd_rec_s = mem_r[rd_addr_s];

  // Record memory; contents survive reset and are writable only while idle.
  always_ff @(posedge sys_clk) begin
    if (wr_en && (state_r == IDLE)) mem_r[wr_addr] <= wr_data;
  end

  // Playback FSM with registered stream and status outputs.
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      state_r     <= IDLE;
      addr_r      <= {AW{1'b0}};
      base_r      <= {AW{1'b0}};
      end_r       <= {AW{1'b0}};
      loop_r      <= 16'd0;
      passes_r    <= 16'd0;
      open_r      <= 1'b0;
      stop_pend_r <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      err_r       <= 1'b0;
      {st_r, rec_end_r, valid_r, data_r} <= {RW{1'b0}};
    end else begin
      done_r <= 1'b0;
      err_r  <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            if (base_addr <= end_addr) begin
              state_r     <= PRIME;
              busy_r      <= 1'b1;
              addr_r      <= base_addr;
              base_r      <= base_addr;
              end_r       <= end_addr;
              loop_r      <= loop_cnt;
              passes_r    <= 16'd0;
              open_r      <= 1'b0;
              stop_pend_r <= 1'b0;
            end else begin
              err_r <= 1'b1;
            end
          end
        end
        PRIME: begin
          {st_r, rec_end_r, valid_r, data_r} <= mask_gap(rd_rec_s);
          if (stop) stop_pend_r <= 1'b1;
          state_r <= PLAY;
        end
        PLAY: begin
          if (stop) stop_pend_r <= 1'b1;
          if (adv_s) begin
            addr_r <= next_addr_s;
            open_r <= open_nx_s;
            if (last_s) passes_r <= passes_nx_s;
            // A finished loop ends playback even inside an open frame.
            if (loop_done_s || stop_now_s) begin
              state_r <= DRAIN;
              {st_r, rec_end_r, valid_r, data_r} <= {RW{1'b0}};
            end else begin
              {st_r, rec_end_r, valid_r, data_r} <= mask_gap(rd_rec_s);
            end
          end
        end
        DRAIN: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b1;
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  assign strm.out_valid = valid_r;
  assign strm.out_st    = st_r;
  assign strm.out_end   = rec_end_r;
  assign strm.out_data  = data_r;
  assign busy           = busy_r;
  assign done           = done_r;
  assign err            = err_r;
  assign passes         = passes_r;
endmodule

// File: tb/tb_stim_stream_player.sv
// Bench for stim_stream_player: cycle-exact vector table, corner sequences and
// randomized windows checked against a record-level reference model.
module tb_stim_stream_player;
  localparam int DATA_W = 16;
  localparam int AW     = 12;

  logic              sys_clk = 1'b0;
  logic              sys_rst;
  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [DATA_W+2:0] wr_data;
  logic              start, stop;
  logic [AW-1:0]     base_addr, end_addr;
  logic [15:0]       loop_cnt;
  logic              busy, done, err;
  logic [15:0]       passes;

  stim_stream_player_if #(.DATA_W(DATA_W)) strm ();

  stim_stream_player #(.DATA_W(DATA_W), .AW(AW), .USE_RDY(1'b1)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .stop(stop), .base_addr(base_addr), .end_addr(end_addr), .loop_cnt(loop_cnt),
    .strm(strm), .busy(busy), .done(done), .err(err), .passes(passes)
  );

  always #5 sys_clk = ~sys_clk;

  int vectors = 0;
  int miscompares = 0;
  logic [18:0] mem_m [0:4095];

  typedef struct {
    logic start, stop, rdy;
    logic [15:0] loop;
    logic exp_valid, exp_st, exp_end;
    logic [15:0] exp_data;
    logic exp_busy, exp_done;
    logic [15:0] exp_passes;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic s, input logic sp, input logic r, input logic [15:0] lp,
                              input logic v, input logic st, input logic en, input logic [15:0] d,
                              input logic b, input logic dn, input logic [15:0] p);
    vec_t x;
    x.start = s; x.stop = sp; x.rdy = r; x.loop = lp;
    x.exp_valid = v; x.exp_st = st; x.exp_end = en; x.exp_data = d;
    x.exp_busy = b; x.exp_done = dn; x.exp_passes = p;
    return x;
  endfunction

  task automatic fail(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    miscompares++;
    $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic wr(input int a, input logic [18:0] d);
    wr_en = 1'b1; wr_addr = a[11:0]; wr_data = d;
    @(posedge sys_clk); #1;
    wr_en = 1'b0;
    mem_m[a] = d;
  endtask

  // Reference: the sequence of dv records a sink must see, plus done timing from stall count.
  task automatic run_model(input int b, input int e, input int lp, input int rdy_pct);
    logic [17:0] exp_q[$];
    logic [18:0] r;
    logic [18:0] prev;
    int n, t, stalls;
    bit hold, got_done;
    exp_q.delete();
    for (int p = 0; p < lp; p++)
      for (int a = b; a <= e; a++) begin
        r = mem_m[a];
        if (r[16]) exp_q.push_back({r[18], r[17], r[15:0]});
      end
    n = lp * (e - b + 1);
    base_addr = b[11:0]; end_addr = e[11:0]; loop_cnt = lp[15:0];
    start = 1'b1;
    @(posedge sys_clk); #1;
    start = 1'b0;
    t = 0; stalls = 0; hold = 1'b0; got_done = 1'b0; prev = 19'd0;
    check("busy_on", busy, 1'b1);
    while (!got_done && t < 4000) begin
      if (hold) check("hold", {strm.out_valid, strm.out_st, strm.out_end, strm.out_data}, prev);
      if (done) begin
        got_done = 1'b1;
        check("done_time", t, n + stalls + 2);
      end else begin
        strm.out_rdy = ($urandom_range(0, 99) < rdy_pct);
        if (strm.out_valid) begin
          if (strm.out_rdy) begin
            if (exp_q.size() == 0) fail("extra_rec", {strm.out_st, strm.out_end, strm.out_data}, 0);
            else check("rec", {strm.out_st, strm.out_end, strm.out_data}, exp_q.pop_front());
          end else begin
            stalls++;
          end
        end
        hold = strm.out_valid && !strm.out_rdy;
        prev = {strm.out_valid, strm.out_st, strm.out_end, strm.out_data};
        @(posedge sys_clk); #1;
        t++;
      end
    end
    if (!got_done) fail("timeout", t, n + stalls + 2);
    check("missing", exp_q.size(), 0);
    check("passes", passes, lp);
    check("busy_off", busy, 1'b0);
    strm.out_rdy = 1'b1;
    @(posedge sys_clk); #1;
    check("done_once", done, 1'b0);
  endtask

  initial begin
    sys_rst = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    start = 1'b0; stop = 1'b0; base_addr = '0; end_addr = '0; loop_cnt = '0;
    strm.out_rdy = 1'b1;
    #3;
    check("reset", {strm.out_valid, strm.out_st, strm.out_end, strm.out_data, busy, done, err, passes}, 0);
    #9 sys_rst = 1'b1;
    @(posedge sys_clk); #1;

    // st,end,dv,data; the gap carries st/end/data bits that must be suppressed.
    wr(0, {1'b1, 1'b0, 1'b1, 16'h1111});
    wr(1, {1'b0, 1'b0, 1'b1, 16'h2222});
    wr(2, {1'b0, 1'b1, 1'b1, 16'h3333});
    wr(3, {1'b1, 1'b1, 1'b0, 16'hbeef});

    // Single pass; then the same with stop coincident with the final (gap) record.
    for (int run = 0; run < 2; run++) begin
      tbl.push_back(mk(1, 0, 1, 1, 0, 0, 0, 16'h0000, 1, 0, 0));
      tbl.push_back(mk(0, 0, 1, 1, 1, 1, 0, 16'h1111, 1, 0, 0));
      tbl.push_back(mk(0, 0, 1, 1, 1, 0, 0, 16'h2222, 1, 0, 0));
      tbl.push_back(mk(0, 0, 1, 1, 1, 0, 1, 16'h3333, 1, 0, 0));
      tbl.push_back(mk(0, 0, 1, 1, 0, 0, 0, 16'h0000, 1, 0, 0));
      tbl.push_back(mk(0, run == 1, 1, 1, 0, 0, 0, 16'h0000, 1, 0, 1));
      tbl.push_back(mk(0, 0, 1, 1, 0, 0, 0, 16'h0000, 0, 1, 1));
      tbl.push_back(mk(0, 0, 1, 1, 0, 0, 0, 16'h0000, 0, 0, 1));
    end
    // Infinite loop, 4-cycle stall on 2222 with a stop inside the frame.
    tbl.push_back(mk(1, 0, 1, 0, 0, 0, 0, 16'h0000, 1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 1, 1, 0, 16'h1111, 1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 1, 0, 0, 16'h2222, 1, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 1, 0, 0, 16'h2222, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 16'h2222, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 16'h2222, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 16'h2222, 1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 1, 0, 1, 16'h3333, 1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 16'h0000, 1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 16'h0000, 0, 1, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 16'h0000, 0, 0, 0));

    base_addr = 12'd0; end_addr = 12'd3;
    foreach (tbl[i]) begin
      start = tbl[i].start; stop = tbl[i].stop; strm.out_rdy = tbl[i].rdy; loop_cnt = tbl[i].loop;
      @(posedge sys_clk); #1;
      check($sformatf("tbl[%0d]", i),
            {strm.out_valid, strm.out_st, strm.out_end, strm.out_data, busy, done, passes},
            {tbl[i].exp_valid, tbl[i].exp_st, tbl[i].exp_end, tbl[i].exp_data,
             tbl[i].exp_busy, tbl[i].exp_done, tbl[i].exp_passes});
    end
    start = 1'b0; stop = 1'b0; strm.out_rdy = 1'b1;

    // Rejected start, then a normal one.
    base_addr = 12'd5; end_addr = 12'd2; loop_cnt = 16'd1; start = 1'b1;
    @(posedge sys_clk); #1;
    start = 1'b0;
    check("err_pulse", {err, busy}, 2'b10);
    @(posedge sys_clk); #1;
    check("err_clear", {err, busy}, 2'b00);
    run_model(0, 3, 1, 100);

    // Async reset mid-frame; a write attempted while busy must not land.
    base_addr = 12'd0; end_addr = 12'd3; loop_cnt = 16'd0; start = 1'b1;
    @(posedge sys_clk); #1;
    start = 1'b0;
    repeat (2) @(posedge sys_clk);
    #1;
    check("pre_rst", strm.out_data, 16'h2222);
    wr_en = 1'b1; wr_addr = 12'd1; wr_data = {1'b0, 1'b0, 1'b1, 16'hdead};
    @(posedge sys_clk); #1;
    wr_en = 1'b0;
    #2 sys_rst = 1'b0;
    #1;
    check("async_rst", {strm.out_valid, strm.out_st, strm.out_end, strm.out_data, busy, done, err, passes}, 0);
    #2 sys_rst = 1'b1;
    @(posedge sys_clk); #1;
    run_model(0, 3, 2, 70);
    run_model(0, 3, 3, 100);

    // Random windows, random loop counts, random backpressure.
    for (int it = 0; it < 6; it++) begin
      int len;
      int b;
      int lp;
      logic [18:0] rec;
      len = $urandom_range(1, 8);
      b   = $urandom_range(0, 4096 - len);
      lp  = $urandom_range(1, 3);
      for (int a = b; a < b + len; a++) begin
        rec = {1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 3) != 0), 16'($urandom)};
        wr(a, rec);
      end
      run_model(b, b + len - 1, lp, 60);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
